rr_arbiter_hold: RTL and testbench
==================================

Name: rr_arbiter_hold

Overview:
- Parametrised N-way round-robin arbiter with registered one-hot grant and grant-hold ("lock") semantics.
- The granted requester keeps the grant while its request stays high, up to a configurable maximum hold time.
- If other requesters are pending when that time expires, the arbiter forces rotation.
- Sits in front of shared resources (bus, memory port, shared FIFO) and replaces fixed 4-way arbitration with a width-generic block.

Parameters:
- N, 4, number of requesters (2..32).
- IDX_W, $clog2(N), width of the grant index.
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while others wait. 0 disables the timeout (pure hold-until-release).
- HOLD_W, 8, width of the hold counter. Must satisfy MAX_HOLD < 2**HOLD_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request vector, one bit per requester, level-sensitive.
- gnt  out  N  registered one-hot grant. All zero when idle.
- gnt_idx  out  IDX_W  binary index of the current owner. 0 when idle.
- gnt_valid  out  1  high when any grant is active.
- gnt_switch  out  1  one-cycle pulse in the cycle a new owner's grant first appears.

Behaviour:
- All outputs are registers.
- Reset (rst high at a clk edge):
  - gnt=0, gnt_idx=0, gnt_valid=0, gnt_switch=0, hold_cnt=0.
  - Last-owner pointer last=N-1, so requester 0 has highest priority first.
- States:
  - IDLE (gnt_valid=0).
  - OWN (gnt_valid=1, owner=gnt_idx).
- Arbitration function:
  - Scan req circularly starting at (last+1) mod N.
  - The first set bit wins.
  - Wrap-around from N-1 to 0 is mandatory.
- IDLE:
  - If |req, the winner is granted at the next edge: OWN, gnt_switch=1, last=winner, hold_cnt=0.
  - Else stay IDLE.
  - Latency from req rising to gnt is 1 cycle.
- OWN, owner's req still high:
  - If MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and any other req bit is set: rotate to the next winner (searching after the owner), gnt_switch=1, hold_cnt=0.
  - Else keep the grant and increment hold_cnt.
  - hold_cnt resets to 0 when it reaches MAX_HOLD-1 with no competitor, so the grant is kept indefinitely.
- OWN, owner's req dropped:
  - If other requests are set, hand over directly at the next edge with no idle bubble (gnt_switch=1).
  - Else go to IDLE (gnt=0, gnt_valid=0).
- Owner can never re-win immediately over a pending competitor after release or timeout.
  - It wins again only if it is the sole requester, in which case gnt_switch=1 and hold_cnt=0.
- Simultaneous requests: strict rotation order from last+1.
- Reset mid-grant: the grant is dropped at the same edge and priority returns to requester 0.
- Invariant: gnt is one-hot or zero, and gnt==(gnt_valid << gnt_idx).
- Requests are not stored: a req pulse shorter than one cycle that loses arbitration is lost.

Optional Feature:
- RR_ARB_MASK_EN defined:
  - Adds an input port req_mask [N], active-high enable.
  - Arbitration and competitor detection use req & req_mask.
  - A masked owner is treated as having released the grant.
- RR_ARB_MASK_EN undefined:
  - No req_mask port; raw req is used.
  - Behaviour is otherwise identical.

Decomposition:
- Shared package rr_arb_pkg holds:
  - the state enum (ST_IDLE, ST_OWN);
  - a function rr_pick(req, start) returning the winner index and found flag;
  - a default MAX_HOLD constant.
- One natural sub-module: rr_priority_pick, a combinational rotate/priority-encode/rotate-back.
  - Instantiated once, reused for both grant selection and competitor detection.
- Top-level holds the state, counter and output registers.

Test Plan:
- N=4, reset then req=4'b1111 held, MAX_HOLD=0 -> gnt=0001 one cycle after reset release, held indefinitely, gnt_switch pulses once.
- N=4, MAX_HOLD=3, req=4'b1111 held -> grant sequence 0001(3 cycles), 0010(3), 0100(3), 1000(3), 0001, with gnt_switch at each change.
- N=4, owner 1 drops req while req=4'b1101 -> gnt goes 0010 -> 0100 at the next edge with no idle cycle.
- Owner 3 drops req with req=4'b0000 -> gnt=0000, gnt_valid=0 next cycle. Then req=4'b1001 -> gnt=0001 (rotation after 3 wraps to 0).
- rst asserted while gnt=0100 -> next edge all outputs 0. Then req=4'b0110 -> gnt=0010.
- With RR_ARB_MASK_EN: req=1111, req_mask=1010 -> grants alternate 0010/1000 only. Clearing mask bit 1 while bit 1 owns -> handover to 1000 next edge.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the hold-capable round-robin arbiter.
// Holds the arbiter state enum, the default hold limit and the circular scan function.
package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam int RR_DEFAULT_MAX_HOLD = 8;
  localparam int RR_MAX_N            = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // Circular scan of the low n bits of req, beginning at start; first set bit wins.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input logic [4:0]          start,
                                       input int                  n);
    rr_pick_t   res;
    logic [4:0] pos;
    int         j;
    res = '0;
    for (int i = 0; i < RR_MAX_N; i++) begin
      j   = (int'(start) + i) % n;
      pos = 5'(j);
      if (i < n && !res.found && req[pos]) begin
        res.found = 1'b1;
        res.idx   = pos;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_hold_pick.sv
// Combinational round-robin pick: rotate req so start lands at bit 0,
// priority-encode, then rotate the winning index back into requester numbering.
module rr_priority_pick
  import rr_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N-1:0]          rot;
  logic [IDX_W:0]        shl;
  logic [RR_MAX_N-1:0]   rot_ext;
  rr_pick_t              enc;
  logic [IDX_W:0]        sum;

  always_comb begin
    // A left shift by N (start == 0) yields zero, so no special case is needed.
    shl     = (IDX_W+1)'(N) - {1'b0, start};
    rot     = (req >> start) | (req << shl);
    rot_ext = '0;
    rot_ext[N-1:0] = rot;
    enc     = rr_pick(rot_ext, 5'd0, N);
    sum     = {1'b0, start} + (IDX_W+1)'(enc.idx);
    if (sum >= (IDX_W+1)'(N)) begin
      sum = sum - (IDX_W+1)'(N);
    end
    idx   = sum[IDX_W-1:0];
    found = enc.found;
  end

endmodule

// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter with registered one-hot grant, grant hold and forced
// rotation after MAX_HOLD cycles. Define RR_ARB_MASK_EN to add the req_mask input.
module rr_arbiter_hold
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = RR_DEFAULT_MAX_HOLD,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
`ifdef RR_ARB_MASK_EN
  input  logic [N-1:0]     req_mask,
`endif
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             gnt_switch
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [N-1:0]      ONE_HOT0  = N'(1);

  arb_state_e        state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              switch_q, switch_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  last_q, last_d;

  logic [N-1:0]      req_eff;
  logic [N-1:0]      cand;
  logic [IDX_W-1:0]  start;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              owner_req;

`ifdef RR_ARB_MASK_EN
  assign req_eff = req & req_mask;
`else
  assign req_eff = req;
`endif

  // Excluding the owner makes one pick serve as both next winner and competitor detect.
  assign cand      = req_eff & ~gnt_q;
  assign start     = (last_q == IDX_W'(N - 1)) ? '0 : last_q + 1'b1;
  assign owner_req = req_eff[idx_q];

  rr_priority_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (cand),
    .start (start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    switch_d = 1'b0;
    hold_d   = hold_q;
    last_d   = last_q;

    if (state_q == ST_OWN && owner_req &&
        !(MAX_HOLD != 0 && hold_q == HOLD_LAST && pick_found)) begin
      hold_d = (MAX_HOLD != 0 && hold_q == HOLD_LAST) ? '0 : hold_q + 1'b1;
    end else if (pick_found) begin
      state_d  = ST_OWN;
      gnt_d    = ONE_HOT0 << pick_idx;
      idx_d    = pick_idx;
      valid_d  = 1'b1;
      switch_d = 1'b1;
      hold_d   = '0;
      last_d   = pick_idx;
    end else if (state_q == ST_OWN) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      switch_q <= 1'b0;
      hold_q   <= '0;
      last_q   <= IDX_W'(N - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      switch_q <= switch_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
    end
  end

  assign gnt        = gnt_q;
  assign gnt_idx    = idx_q;
  assign gnt_valid  = valid_q;
  assign gnt_switch = switch_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Directed bench for rr_arbiter_hold: one instance without timeout, one with MAX_HOLD=3.
module tb_rr_arbiter_hold;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req0 = '0;
  logic [3:0] req3 = '0;
  logic [3:0] gnt0, gnt3;
  logic [1:0] idx0, idx3;
  logic       valid0, valid3, sw0, sw3;
`ifdef RR_ARB_MASK_EN
  logic [3:0] mask0 = 4'b1111;
  logic [3:0] mask3 = 4'b1111;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter_hold #(.N(4), .MAX_HOLD(0), .HOLD_W(8)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .req        (req0),
`ifdef RR_ARB_MASK_EN
    .req_mask   (mask0),
`endif
    .gnt        (gnt0),
    .gnt_idx    (idx0),
    .gnt_valid  (valid0),
    .gnt_switch (sw0)
  );

  rr_arbiter_hold #(.N(4), .MAX_HOLD(3), .HOLD_W(8)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .req        (req3),
`ifdef RR_ARB_MASK_EN
    .req_mask   (mask3),
`endif
    .gnt        (gnt3),
    .gnt_idx    (idx3),
    .gnt_valid  (valid3),
    .gnt_switch (sw3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = '0; req3 = '0;
    step(); step();
    checks++;
    if ({gnt0, idx0, valid0, sw0} !== 8'b0) begin
      failures++; $display("FAIL reset_dut0: got %b expected 00000000", {gnt0, idx0, valid0, sw0});
    end
    checks++;
    if ({gnt3, idx3, valid3, sw3} !== 8'b0) begin
      failures++; $display("FAIL reset_dut3: got %b expected 00000000", {gnt3, idx3, valid3, sw3});
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_hold_forever();
    int nsw;
    req0 = 4'b1111;
    step();
    checks++;
    if ({gnt0, idx0, valid0, sw0} !== 8'b0001_00_1_1) begin
      failures++; $display("FAIL hold_first_grant: got %b expected 00010011", {gnt0, idx0, valid0, sw0});
    end
    nsw = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sw0) nsw++;
      checks++;
      if (gnt0 !== 4'b0001) begin
        failures++; $display("FAIL hold_keep[%0d]: got %b expected 0001", i, gnt0);
      end
    end
    checks++;
    if (nsw !== 0) begin
      failures++; $display("FAIL hold_no_extra_switch: got %0d expected 0", nsw);
    end
    $display("test_hold_forever done");
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    logic [1:0] exp_i;
    logic       exp_s;
    req3 = 4'b1111;
    for (int k = 0; k < 13; k++) begin
      step();
      exp_i = 2'((k / 3) % 4);
      exp_g = 4'b0001 << exp_i;
      exp_s = (k % 3 == 0);
      checks++;
      if ({gnt3, idx3, sw3} !== {exp_g, exp_i, exp_s}) begin
        failures++;
        $display("FAIL rotate[%0d]: got gnt=%b idx=%0d sw=%b expected gnt=%b idx=%0d sw=%b",
                 k, gnt3, idx3, sw3, exp_g, exp_i, exp_s);
      end
    end
    req3 = 4'b0000;
    step();
    checks++;
    if ({gnt3, valid3} !== 5'b0000_0) begin
      failures++; $display("FAIL rotate_release: got gnt=%b valid=%b expected 0000 0", gnt3, valid3);
    end
    $display("test_rotation done");
  endtask

  task automatic test_handover();
    req3 = 4'b0010;
    step();
    checks++;
    if ({gnt3, sw3} !== 5'b0010_1) begin
      failures++; $display("FAIL handover_own1: got gnt=%b sw=%b expected 0010 1", gnt3, sw3);
    end
    req3 = 4'b1101;
    step();
    checks++;
    if ({gnt3, valid3, sw3} !== 6'b0100_1_1) begin
      failures++; $display("FAIL handover_1_to_2: got gnt=%b valid=%b sw=%b expected 0100 1 1", gnt3, valid3, sw3);
    end
    req3 = 4'b1001;
    step();
    checks++;
    if ({gnt3, idx3} !== 6'b1000_11) begin
      failures++; $display("FAIL handover_2_to_3: got gnt=%b idx=%0d expected 1000 3", gnt3, idx3);
    end
    req3 = 4'b0000;
    step();
    checks++;
    if ({gnt3, idx3, valid3, sw3} !== 8'b0) begin
      failures++; $display("FAIL handover_idle: got %b expected 00000000", {gnt3, idx3, valid3, sw3});
    end
    req3 = 4'b1001;
    step();
    checks++;
    if ({gnt3, idx3, sw3} !== 7'b0001_00_1) begin
      failures++; $display("FAIL handover_wrap: got gnt=%b idx=%0d sw=%b expected 0001 0 1", gnt3, idx3, sw3);
    end
    $display("test_handover done");
  endtask

  task automatic test_reset_mid();
    req3 = 4'b0100;
    step();
    checks++;
    if (gnt3 !== 4'b0100) begin
      failures++; $display("FAIL midrst_setup: got %b expected 0100", gnt3);
    end
    rst = 1'b1; req3 = 4'b0110;
    step();
    checks++;
    if ({gnt3, idx3, valid3, sw3} !== 8'b0) begin
      failures++; $display("FAIL midrst_clear: got %b expected 00000000", {gnt3, idx3, valid3, sw3});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({gnt3, idx3, valid3, sw3} !== 8'b0010_01_1_1) begin
      failures++; $display("FAIL midrst_regrant: got %b expected 00100111", {gnt3, idx3, valid3, sw3});
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_sole_timeout();
    req3 = 4'b0010;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if ({gnt3, sw3} !== 5'b0010_0) begin
        failures++; $display("FAIL sole_keep[%0d]: got gnt=%b sw=%b expected 0010 0", i, gnt3, sw3);
      end
    end
    req3 = 4'b0011;
    step();
    checks++;
    if (gnt3 !== 4'b0010) begin
      failures++; $display("FAIL sole_cnt1: got %b expected 0010", gnt3);
    end
    step();
    checks++;
    if (gnt3 !== 4'b0010) begin
      failures++; $display("FAIL sole_cnt2: got %b expected 0010", gnt3);
    end
    step();
    checks++;
    if ({gnt3, sw3} !== 5'b0001_1) begin
      failures++; $display("FAIL sole_force_rotate: got gnt=%b sw=%b expected 0001 1", gnt3, sw3);
    end
    $display("test_sole_timeout done");
  endtask

`ifdef RR_ARB_MASK_EN
  task automatic test_mask();
    logic [3:0] exp_g;
    rst = 1'b1;
    step();
    rst = 1'b0; req3 = 4'b1111; mask3 = 4'b1010;
    for (int k = 0; k < 7; k++) begin
      step();
      exp_g = (((k / 3) % 2) == 1) ? 4'b1000 : 4'b0010;
      checks++;
      if ({gnt3, sw3} !== {exp_g, (k % 3 == 0)}) begin
        failures++; $display("FAIL mask_alt[%0d]: got gnt=%b sw=%b expected %b %b", k, gnt3, sw3, exp_g, (k % 3 == 0));
      end
    end
    mask3 = 4'b1000;
    step();
    checks++;
    if ({gnt3, sw3} !== 5'b1000_1) begin
      failures++; $display("FAIL mask_owner_drop: got gnt=%b sw=%b expected 1000 1", gnt3, sw3);
    end
    $display("test_mask done");
  endtask
`endif

  initial begin
    test_reset();
    test_hold_forever();
    test_rotation();
    test_handover();
    test_reset_mid();
    test_sole_timeout();
`ifdef RR_ARB_MASK_EN
    test_mask();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
